feistel_core_param: RTL and testbench
=====================================

FEISTEL_CORE_PARAM -- requirements
Module: feistel_core_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, block and key width in bits; it SHALL be even and at least 8.
REQ-002 The block SHALL have parameter ROUNDS, default 16, number of Feistel rounds; legal range is 1 to 31.
REQ-003 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request to accept a new block; sampled only while Ready=1.
REQ-006 Mode  input  1  0 selects encrypt, 1 selects decrypt; latched with Start.
REQ-007 Plaintext  input  WIDTH  input block; latched with Start.
REQ-008 Key_in  input  WIDTH  key; latched with Start.
REQ-009 Ready  output  1  high when the block can accept Start.
REQ-010 Counter_machine  output  5  current round index.
REQ-011 Cirphertext  output  WIDTH  result register; holds its value until the next Done.
REQ-012 Done  output  1  one-cycle pulse marking a new valid Cirphertext.

Function
REQ-013 The block SHALL use a one-hot or encoded FSM with states IDLE, ROUND and DONE.
REQ-014 Ready SHALL be 1 in IDLE and DONE and 0 in ROUND.
REQ-015 A rising edge with Start=1 and Ready=1 SHALL perform all of the following:
- latch L = Plaintext[WIDTH-1:WIDTH/2] and R = Plaintext[WIDTH/2-1:0];
- latch Key_in and Mode;
- set Counter_machine to 0;
- enter ROUND.
REQ-016 Start SHALL be ignored while Ready=0.
REQ-017 The round key for round n SHALL be K(n) = low WIDTH/2 bits of (latched key rotated left by n mod WIDTH).
REQ-018 The round function SHALL be F(R,K) = (rotl(R xor K, 3) + K) mod 2^(WIDTH/2).
- The rotation is over WIDTH/2 bits.
- The addition carry is discarded.
REQ-019 Each edge in ROUND SHALL execute exactly one round with round index i = Counter_machine:
- new L = R;
- new R = L xor F(R, K(n));
- n = i when Mode=0, n = ROUNDS-1-i when Mode=1.
REQ-020 Counter_machine SHALL increment by 1 per round.
REQ-021 On the edge executing round i = ROUNDS-1, the FSM SHALL:
- load Cirphertext = {R_new, L_new} (final halves swapped back);
- set Done=1;
- enter DONE.
REQ-022 Latency SHALL be fixed: Done SHALL be high in the cycle following the ROUNDS-th edge after the accepting edge, and for exactly one cycle.
REQ-023 In DONE, Start=1 SHALL be accepted as in REQ-015 (back-to-back operation, no idle cycle required); otherwise the FSM SHALL go to IDLE.
REQ-024 Decrypting an encrypt result with the same key, WIDTH and ROUNDS SHALL return the original Plaintext bit-exactly.
REQ-025 Changes to Plaintext, Key_in or Mode during ROUND SHALL NOT affect the result in flight.
REQ-026 Counter_machine SHALL hold its last value in DONE and IDLE until the next accept.
REQ-027 The block SHALL have no combinational path from any input to any output.

Reset
REQ-028 Reset=1 SHALL immediately force the following, regardless of clock:
- state IDLE;
- Counter_machine=0, Done=0, Cirphertext=0;
- L=0, R=0 and latched key/mode cleared;
- Ready=1.
REQ-029 Reset asserted mid-operation SHALL abort the block with no Done pulse; the first Start after release SHALL be processed normally.
REQ-030 Start sampled on an edge while Reset=1 SHALL be ignored.

Verification
REQ-031 Bench SHALL cover all-zeros: WIDTH=128, ROUNDS=16, Plaintext=0, Key_in=0, Mode=0 -> Cirphertext=0, with Done exactly 17 edges after the accepting edge's cycle (ROUNDS edges, then the Done cycle).
REQ-032 Bench SHALL cover a minimal configuration: WIDTH=8, ROUNDS=1, Plaintext=8'h12, Key_in=8'h00, Mode=0 -> Cirphertext=8'h02, with Done one cycle after the accepting edge's following edge.
REQ-033 Bench SHALL cover a round trip: WIDTH=128, Plaintext=128'h80808080808080808080808080808080, Key_in=128'hE00A6E5724C52BC352DEC4F83972E00A.
- Encrypt -> result C.
- Decrypt C with the same key -> Cirphertext equals the Plaintext above.
REQ-034 Bench SHALL cover back-to-back operation: Start held high with new data in the DONE cycle -> Done pulses exactly 17 cycles apart; each result matches a reference model of REQ-017..REQ-021.
REQ-035 Bench SHALL cover busy rejection: Start pulsed with different Plaintext at round 5 -> ignored; Ready=0; result equals that of the original block.
REQ-036 Bench SHALL cover reset mid-operation: Reset pulsed at round 8, asynchronous to Clk -> outputs reach reset values immediately, no Done, and the next operation is correct.

Source files
------------

// File: rtl/feistel_core_param_if.sv
// Handshake and data bundle between a Feistel core and its requester.
// The master drives requests and the slave (the core) returns status and results.
interface feistel_core_param_if #(
  parameter int WIDTH = 128
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] plaintext;
  logic [WIDTH-1:0] key_in;
  logic             ready;
  logic [4:0]       counter_machine;
  logic [WIDTH-1:0] cirphertext;
  logic             done;

  modport master (
    output start, mode, plaintext, key_in,
    input  ready, counter_machine, cirphertext, done
  );

  modport slave (
    input  start, mode, plaintext, key_in,
    output ready, counter_machine, cirphertext, done
  );
endinterface

// File: rtl/feistel_core_param.sv
// Iterative Feistel cipher core: one round per clock, key schedule by key rotation.
// Decryption reuses the same datapath with the round keys applied in reverse order.
module feistel_core_param #(
  parameter int WIDTH  = 128,
  parameter int ROUNDS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  feistel_core_param_if.slave  bus
);
  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [HALF-1:0]  l_q, l_d;
  logic [HALF-1:0]  r_q, r_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] ct_q, ct_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [4:0]       rnd_s;
  logic [HALF-1:0]  f_s;

  // Rotate the full key left by n and keep its low half.
  function automatic logic [HALF-1:0] round_key(input logic [WIDTH-1:0] k, input logic [4:0] n);
    int unsigned s;
    s = 32'(n) % WIDTH;
    return HALF'((k << s) | (k >> (WIDTH - s)));
  endfunction

  // Round function: rotate (R xor K) left by 3 within the half, then add K modulo 2^HALF.
  function automatic logic [HALF-1:0] feistel_f(input logic [HALF-1:0] r, input logic [HALF-1:0] k);
    logic [HALF-1:0] x;
    x = r ^ k;
    return {x[HALF-4:0], x[HALF-1:HALF-3]} + k;
  endfunction

  assign rnd_s = mode_q ? (5'(ROUNDS - 1) - cnt_q) : cnt_q;
  assign f_s   = feistel_f(r_q, round_key(key_q, rnd_s));

  // Next-state and datapath update for the IDLE/ROUND/DONE sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    key_d   = key_q;
    mode_d  = mode_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start && ready_q) begin
          l_d     = bus.plaintext[WIDTH-1:HALF];
          r_d     = bus.plaintext[HALF-1:0];
          key_d   = bus.key_in;
          mode_d  = bus.mode;
          cnt_d   = 5'd0;
          state_d = ST_ROUND;
          ready_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_ROUND: begin
        l_d   = r_q;
        r_d   = l_q ^ f_s;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ROUNDS - 1)) begin
          // Halves are swapped back so decryption is the same datapath run in reverse key order.
          ct_d    = {l_q ^ f_s, r_q};
          done_d  = 1'b1;
          state_d = ST_DONE;
          ready_d = 1'b1;
        end else begin
          state_d = ST_ROUND;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State register with asynchronous reset to an idle, cleared core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      l_q     <= '0;
      r_q     <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      ct_q    <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready           = ready_q;
  assign bus.counter_machine = cnt_q;
  assign bus.cirphertext     = ct_q;
  assign bus.done            = done_q;
endmodule

// File: tb/tb_feistel_core_param.sv
// Self-checking bench: a 128-bit/16-round core and an 8-bit/1-round core checked
// against a loop-based Feistel reference model, fixed vectors and corner-case sequences.
module tb_feistel_core_param;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  feistel_core_param_if #(.WIDTH(128)) bus_a ();
  feistel_core_param_if #(.WIDTH(8))   bus_b ();

  feistel_core_param #(.WIDTH(128), .ROUNDS(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  feistel_core_param #(.WIDTH(8),   .ROUNDS(1))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] RT_PT  = 128'h80808080808080808080808080808080;
  localparam logic [127:0] RT_KEY = 128'hE00A6E5724C52BC352DEC4F83972E00A;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: rotations done one bit at a time, widths handled by masking.
  function automatic logic [127:0] model(int w, int rounds, logic [127:0] pt, logic [127:0] key, logic m);
    int h;
    int n;
    logic [127:0] wm, hm, l, r, kk, k, x, t;
    h  = w / 2;
    wm = '1;
    if (w < 128) wm = (128'd1 << w) - 128'd1;
    hm = (128'd1 << h) - 128'd1;
    l  = (pt >> h) & hm;
    r  = pt & hm;
    for (int i = 0; i < rounds; i++) begin
      n  = m ? (rounds - 1 - i) : i;
      kk = key & wm;
      for (int j = 0; j < (n % w); j++) kk = ((kk << 1) | (kk >> (w - 1))) & wm;
      k = kk & hm;
      x = (r ^ k) & hm;
      for (int j = 0; j < 3; j++) x = ((x << 1) | (x >> (h - 1))) & hm;
      t = l ^ ((x + k) & hm);
      l = r;
      r = t;
    end
    return (r << h) | l;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Runs one block on the wide core; optionally injects a busy Start or an async reset.
  task automatic do_op(input logic m, input logic [127:0] p, input logic [127:0] k,
                       input int busy_at, input int rst_at,
                       output logic [127:0] ct, output int lat);
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.mode = m; bus_a.plaintext = p; bus_a.key_in = k;
    @(posedge clk);
    lat = 0;
    ct  = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bus_a.start = 1'b0; bus_a.plaintext = rnd128(); bus_a.key_in = rnd128();
      bus_a.mode = 1'($urandom);
      if (c - 1 == busy_at) begin
        chk("busy_ready", bus_a.ready, 128'd0);
        chk("busy_counter", bus_a.counter_machine, 128'(busy_at));
        bus_a.start = 1'b1;
      end
      if (c - 1 == rst_at) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_done", bus_a.done, 128'd0);
        chk("rst_ct", bus_a.cirphertext, 128'd0);
        chk("rst_counter", bus_a.counter_machine, 128'd0);
        chk("rst_ready", bus_a.ready, 128'd1);
        #1 rst = 1'b0;
        break;
      end
      if (bus_a.done) begin
        lat = c;
        ct  = bus_a.cirphertext;
        break;
      end
    end
  endtask

  task automatic do_small(input logic [7:0] p, input logic [7:0] k, input logic m,
                          output logic [7:0] ct, output int lat);
    @(negedge clk);
    bus_b.start = 1'b1; bus_b.mode = m; bus_b.plaintext = p; bus_b.key_in = k;
    @(posedge clk);
    lat = 0;
    ct  = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus_b.start = 1'b0; bus_b.plaintext = 8'($urandom);
      if (bus_b.done) begin
        lat = c;
        ct  = bus_b.cirphertext;
        break;
      end
    end
  endtask

  initial begin
    vec_t         vecs[9];
    logic [127:0] ct, ct1, p1, p2, k1, k2;
    logic [7:0]   cts, ps, ks;
    logic         ms;
    int           lat, t1, t2;
    logic         seen_done;

    n_chk = 0;
    n_err = 0;

    // Start held high across edges while in reset must be ignored.
    rst = 1'b1;
    bus_a.start = 1'b1; bus_a.mode = 1'b0; bus_a.plaintext = rnd128(); bus_a.key_in = rnd128();
    bus_b.start = 1'b1; bus_b.mode = 1'b0; bus_b.plaintext = 8'h5A;    bus_b.key_in = 8'h3C;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", bus_a.ready, 128'd1);
    chk("reset_done", bus_a.done, 128'd0);
    chk("reset_ct", bus_a.cirphertext, 128'd0);
    chk("reset_counter", bus_a.counter_machine, 128'd0);
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", bus_a.ready, 128'd1);

    vecs[0] = '{1'b0, 128'd0, 128'd0, 128'd0};
    vecs[1] = '{1'b0, RT_PT, RT_KEY, model(128, 16, RT_PT, RT_KEY, 1'b0)};
    vecs[2] = '{1'b1, model(128, 16, RT_PT, RT_KEY, 1'b0), RT_KEY, RT_PT};
    for (int i = 3; i < 9; i++) begin
      vecs[i].mode = 1'($urandom);
      vecs[i].pt   = rnd128();
      vecs[i].key  = rnd128();
      vecs[i].exp  = model(128, 16, vecs[i].pt, vecs[i].key, vecs[i].mode);
    end
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].mode, vecs[i].pt, vecs[i].key, -1, -1, ct, lat);
      chk($sformatf("vec%0d_ct", i), ct, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd17);
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), bus_a.done, 128'd0);
    end

    // Minimal configuration plus random checks on the narrow core.
    do_small(8'h12, 8'h00, 1'b0, cts, lat);
    chk("small_ct", 128'(cts), 128'h02);
    chk("small_latency", 128'(lat), 128'd2);
    for (int i = 0; i < 6; i++) begin
      ps = 8'($urandom); ks = 8'($urandom); ms = 1'($urandom);
      do_small(ps, ks, ms, cts, lat);
      chk($sformatf("small_rand%0d", i), 128'(cts), model(8, 1, 128'(ps), 128'(ks), ms));
    end

    // Back-to-back: new Start presented in the DONE cycle.
    p1 = rnd128(); k1 = rnd128(); p2 = rnd128(); k2 = rnd128();
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.mode = 1'b0; bus_a.plaintext = p1; bus_a.key_in = k1;
    @(posedge clk);
    t1 = 0; t2 = 0; ct1 = '0; ct = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      if (bus_a.done && t1 == 0) begin
        t1  = c;
        ct1 = bus_a.cirphertext;
        bus_a.start = 1'b1; bus_a.mode = 1'b0; bus_a.plaintext = p2; bus_a.key_in = k2;
      end else if (bus_a.done) begin
        t2 = c;
        ct = bus_a.cirphertext;
        break;
      end
    end
    chk("b2b_first_ct", ct1, model(128, 16, p1, k1, 1'b0));
    chk("b2b_second_ct", ct, model(128, 16, p2, k2, 1'b0));
    chk("b2b_spacing", 128'(t2 - t1), 128'd17);

    // Busy rejection at round 5.
    p1 = rnd128(); k1 = rnd128();
    do_op(1'b0, p1, k1, 5, -1, ct, lat);
    chk("busy_ct", ct, model(128, 16, p1, k1, 1'b0));
    chk("busy_latency", 128'(lat), 128'd17);
    @(negedge clk);
    chk("busy_no_restart", bus_a.ready, 128'd1);

    // Reset mid-operation at round 8, then no Done and a clean next block.
    do_op(1'b0, rnd128(), rnd128(), -1, 8, ct, lat);
    seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_a.done) seen_done = 1'b1;
    end
    chk("rst_no_done", 128'(seen_done), 128'd0);
    p1 = rnd128(); k1 = rnd128();
    do_op(1'b1, p1, k1, -1, -1, ct, lat);
    chk("after_rst_ct", ct, model(128, 16, p1, k1, 1'b1));
    chk("after_rst_latency", 128'(lat), 128'd17);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
